// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_pkg
// Brief   : Shared state encoding and byte-lane width for the wide adder.
// Revision: 1.0 - initial release
// ============================================================================
package wide_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/carryskipadd.sv
`default_nettype none
// ============================================================================
// Module  : carryskipadd
// Brief   : 8-bit carry-skip adder built from two 4-bit ripple groups.
// Revision: 1.0 - initial release
// ============================================================================
module carryskipadd
    import wide_add_pkg::*;
(
    output logic [BYTE_W-1:0] sum,
    output logic              carry_out,
    input  logic [BYTE_W-1:0] in1,
    input  logic [BYTE_W-1:0] in2,
    input  logic              carry_in
);

    localparam int GRP_W = 4;

    logic [BYTE_W-1:0] w_p;
    logic [BYTE_W-1:0] w_g;
    logic [BYTE_W:0]   w_c;

    assign w_p = in1 ^ in2;
    assign w_g = in1 & in2;

    // A fully propagating group forwards its incoming carry directly.
    always_comb begin : p_carry
        logic [BYTE_W:0] c;
        c    = '0;
        c[0] = carry_in;
        for (int i = 0; i < BYTE_W; i++) begin
            c[i+1] = w_g[i] | (w_p[i] & c[i]);
            if ((i % GRP_W) == (GRP_W - 1)) begin
                if (&w_p[(i / GRP_W) * GRP_W +: GRP_W]) begin
                    c[i+1] = c[(i / GRP_W) * GRP_W];
                end
            end
        end
        w_c = c;
    end

    assign sum       = w_p ^ w_c[BYTE_W-1:0];
    assign carry_out = w_c[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/wide_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_scheduler
// Brief   : Two-requester round-robin front end for a byte-serial wide adder.
//           Define WIDE_ADD_SUB_EN to add per-requester subtract inputs.
// Revision: 1.0 - initial release
// ============================================================================
module wide_add_scheduler
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic         req_cin0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic         req_cin1,
`ifdef WIDE_ADD_SUB_EN
    input  logic         req_sub0,
    input  logic         req_sub1,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_id,
    output logic         busy
);

    localparam int              IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              id_q, id_d;
    logic              prio_q, prio_d;

    logic [1:0]        w_sub;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic [W-1:0]      w_a_sel;
    logic [W-1:0]      w_b_sel;
    logic              w_cin_sel;
    logic              w_sub_sel;
    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_byte_sum;
    logic              w_byte_cout;

`ifdef WIDE_ADD_SUB_EN
    assign w_sub = {req_sub1, req_sub0};
`else
    assign w_sub = 2'b00;
`endif

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = prio_q;
        if (req_valid[prio_q]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = prio_q;
        end else if (req_valid[~prio_q]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~prio_q;
        end
    end

    assign w_a_sel   = w_grant_id ? req_a1   : req_a0;
    assign w_b_sel   = w_grant_id ? req_b1   : req_b0;
    assign w_cin_sel = w_grant_id ? req_cin1 : req_cin0;
    assign w_sub_sel = w_sub[w_grant_id];

    assign w_a_byte = a_q[idx_q * BYTE_W +: BYTE_W];
    assign w_b_byte = b_q[idx_q * BYTE_W +: BYTE_W];

    carryskipadd u_adder (
        .sum       (w_byte_sum),
        .carry_out (w_byte_cout),
        .in1       (w_a_byte),
        .in2       (w_b_byte),
        .carry_in  (carry_q)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        id_d      = id_q;
        prio_d    = prio_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                if (w_grant_valid) begin
                    req_ready[w_grant_id] = 1'b1;
                    state_d = RUN;
                    id_d    = w_grant_id;
                    prio_d  = ~w_grant_id;
                    idx_d   = '0;
                    a_d     = w_a_sel;
                    // Subtract is A + ~B + 1; the final carry then reads as "no borrow".
                    b_d     = w_sub_sel ? ~w_b_sel : w_b_sel;
                    carry_d = w_sub_sel ? 1'b1 : w_cin_sel;
                end
            end
            RUN: begin
                sum_d[idx_q * BYTE_W +: BYTE_W] = w_byte_sum;
                carry_d = w_byte_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = carry_q;
    assign res_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_wide_add_scheduler
// Brief   : Scoreboard bench: directed vectors plus random two-requester traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wide_add_scheduler;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    logic         op_cin [2];
`ifdef WIDE_ADD_SUB_EN
    logic         op_sub [2];
`endif
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
    logic         busy;

    always #5 clk = ~clk;

    wide_add_scheduler #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (op_a[0]),
        .req_b0    (op_b[0]),
        .req_cin0  (op_cin[0]),
        .req_a1    (op_a[1]),
        .req_b1    (op_b[1]),
        .req_cin1  (op_cin[1]),
`ifdef WIDE_ADD_SUB_EN
        .req_sub0  (op_sub[0]),
        .req_sub1  (op_sub[1]),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   acc_count = 0;
    int   hs_count  = 0;
    logic prio_m    = 1'b0;
    bit   force_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference result: plain W-bit arithmetic, subtraction reports "no borrow".
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
        if (sub) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic sub_eff(input logic id);
`ifdef WIDE_ADD_SUB_EN
        return op_sub[id];
`else
        return 1'b0 & id;
`endif
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) == 0) v = '1;
        return v;
    endfunction

    // One clock: check the handshake against the round-robin rule, log accepts.
    task automatic step();
        logic [1:0]   exp_rdy;
        logic         g;
        logic         accepted;
        logic [W:0]   r;
        exp_t         e;
        accepted = 1'b0;
        g        = prio_m;
        @(negedge clk);
        if (rst) begin
            prio_m    = 1'b0;
            acc_count = hs_count;
        end else begin
            exp_rdy = 2'b00;
            if (acc_count == hs_count) begin
                if (req_valid[prio_m]) begin
                    g = prio_m;
                    exp_rdy[g] = 1'b1;
                end else if (req_valid[~prio_m]) begin
                    g = ~prio_m;
                    exp_rdy[g] = 1'b1;
                end
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(acc_count != hs_count));
            if (exp_rdy != 2'b00) begin
                r      = ref_result(op_a[g], op_b[g], op_cin[g], sub_eff(g));
                e.sum  = r[W-1:0];
                e.cout = r[W];
                e.id   = g;
                e.due  = cyc + 1 + NBYTES;
                sb.push_back(e);
                acc_count++;
                prio_m   = ~g;
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (accepted) begin
            req_valid[g] = 1'b0;
            op_a[g]      = $urandom;
            op_b[g]      = $urandom;
            op_cin[g]    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((req_valid != 2'b00 || acc_count != hs_count) && n < bound) begin
            step();
            n++;
        end
        chk("drain", 64'({req_valid != 2'b00, acc_count != hs_count}), 64'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_res_sum",   64'(res_sum),   64'd0);
        chk("rst_res_cout",  64'(res_cout),  64'd0);
        chk("rst_res_id",    64'(res_id),    64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        op_a[i]   = a;
        op_b[i]   = b;
        op_cin[i] = cin;
    endtask

    // Result monitor: owns res_ready and pops the scoreboard on each handshake.
    initial begin : monitor
        int   stall;
        bit   seen;
        exp_t e;
        stall     = 0;
        seen      = 1'b0;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb.delete();
                seen      = 1'b0;
                stall     = 0;
                res_ready = 1'b0;
                continue;
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("res_valid_unexpected", 64'(res_valid), 64'd0);
                    res_ready = 1'($urandom_range(0, 1));
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen  = 1'b1;
                        chk("latency", 64'(cyc), 64'(e.due));
                        stall = force_stall ? 5 : $urandom_range(0, 2);
                    end
                    res_ready = (stall == 0);
                    if (stall > 0) stall--;
                    chk("res_sum",  64'(res_sum),  64'(e.sum));
                    chk("res_cout", 64'(res_cout), 64'(e.cout));
                    chk("res_id",   64'(res_id),   64'(e.id));
                    if (res_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                        hs_count++;
                    end
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("res_valid_late", 64'(res_valid), 64'd1);
                    void'(sb.pop_front());
                    seen = 1'b0;
                    hs_count++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        rst       = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            set_op(i, '0, '0, 1'b0);
`ifdef WIDE_ADD_SUB_EN
            op_sub[i] = 1'b0;
`endif
        end
        repeat (3) step();
        rst = 1'b0;
        check_reset_outputs();

        // Both requesters raised straight out of reset: 0 first, then 1.
        set_op(0, 32'h0000_00AC, 32'h0000_0031, 1'b0);
        set_op(1, 32'h0000_00B1, 32'h0000_003A, 1'b1);
        req_valid = 2'b11;
        wait_idle(100);

        // Carry ripples through every byte.
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 2'b01;
        wait_idle(100);

        // Result held under back-pressure.
        force_stall = 1'b1;
        set_op(1, $urandom, $urandom, 1'b1);
        req_valid = 2'b10;
        wait_idle(100);
        force_stall = 1'b0;

        // Abort in the second RUN cycle; priority must restart at requester 0.
        set_op(0, $urandom, $urandom, 1'b0);
        req_valid = 2'b01;
        n = 0;
        while (req_valid[0] && n < 20) begin
            step();
            n++;
        end
        chk("abort_accept", 64'(req_valid[0]), 64'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        set_op(0, $urandom, $urandom, 1'b1);
        set_op(1, $urandom, $urandom, 1'b0);
        req_valid = 2'b11;
        wait_idle(100);

`ifdef WIDE_ADD_SUB_EN
        set_op(0, 32'h0000_00B1, 32'h0000_003A, 1'b0);
        op_sub[0] = 1'b1;
        req_valid = 2'b01;
        wait_idle(100);
        op_sub[0] = 1'b0;
`endif

        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
`ifdef WIDE_ADD_SUB_EN
                    op_sub[i] = 1'($urandom_range(0, 1));
`endif
                    req_valid[i] = 1'b1;
                end
            end
            step();
        end
        wait_idle(300);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
